btb_upd_sched: RTL and testbench
================================

// Module: btb_upd_sched
// PURPOSE
//  Schedules every write into the branch target buffer from a single write port.
//  - Arbitrates update requests from EX (branch resolution) and ID (direct jal target).
//  - Sequences a full-table invalidate walk on flush (fence.i / context change).
//  - Sits between the pipeline stages and the BTB storage; the BTB itself only sees btb_wr_*.
// PARAMETERS
//  ADDR_W      32  PC / target width in bits
//  DEPTH       16  BTB entries (power of 2, >= 2)
//  IDX_W        4  log2(DEPTH)
//  STARVE_LIM   4  cycles ID may wait before it gains priority (only with BTB_STARVE_GUARD_EN)
// PORTS
//  clk             in   1                    clock
//  rst_n           in   1                    async reset, active low
//  ex_valid_i      in   1                    EX update request
//  ex_ready_o      out  1                    EX request accepted this cycle when valid & ready
//  ex_pc_i         in   ADDR_W               PC of the resolved branch
//  ex_target_i     in   ADDR_W               resolved target
//  ex_taken_i      in   1                    1 = install entry, 0 = invalidate entry
//  id_valid_i      in   1                    ID jal install request
//  id_ready_o      out  1                    ID accept
//  id_pc_i         in   ADDR_W               jal PC
//  id_target_i     in   ADDR_W               jal target
//  flush_req_i     in   1                    single-cycle pulse: invalidate the whole BTB
//  btb_wr_en_o     out  1                    one-cycle write strobe
//  btb_wr_idx_o    out  IDX_W                entry index = pc[IDX_W+1:2]
//  btb_wr_tag_o    out  ADDR_W-IDX_W-2       tag = pc[ADDR_W-1:IDX_W+2]
//  btb_wr_target_o out  ADDR_W               target written
//  btb_wr_valid_o  out  1                    valid bit written
//  busy_o          out  1                    flush walk in progress
//  flush_done_o    out  1                    one-cycle pulse after the last flush write
// BEHAVIOUR
//  - Reset: every output and every register is 0; FSM in IDLE.
//  - FSM states and transitions:
//    - IDLE -> FLUSH on flush_req_i; walk counter loads 0.
//    - FLUSH: writes index cnt with valid=0 each cycle; cnt increments.
//    - FLUSH -> IDLE after the write of index DEPTH-1; flush_done_o pulses in that cycle +1.
//    - flush_req_i while in FLUSH restarts the walk at index 0; no flush_done_o for the aborted walk.
//  - Readiness: ex_ready_o = IDLE & !flush_req_i; id_ready_o = ex_ready_o & !ex_valid_i.
//  - Priority: flush > EX > ID. A losing requester holds valid and its payload until accepted.
//  - Latency: a request accepted in cycle N drives btb_wr_* in cycle N+1 for exactly one cycle.
//  - Write payload:
//    - EX: btb_wr_valid_o = ex_taken_i.
//    - ID: btb_wr_valid_o = 1.
//    - Flush: tag and target 0, valid 0.
//  - Back-to-back acceptance is allowed, one request per cycle.
//  - PC bits [1:0] are ignored. Index wraps naturally (aliasing is accepted).
//  - Reset mid-flush: returns to IDLE immediately, and flush_done_o is never asserted;
//    partially cleared entries are the BTB's reset responsibility.
// CONFIGURATION
//  - BTB_STARVE_GUARD_EN defined:
//    - a wait counter increments each cycle id_valid_i & !id_ready_o in IDLE.
//    - At STARVE_LIM, ID gets priority over EX for one accept:
//      id_ready_o = IDLE & !flush_req_i; ex_ready_o = 0.
//    - The counter clears on ID accept, and on flush.
//  - Undefined: strict EX > ID priority; no counter exists.
// STRUCTURE
//  - Shared header btb_defs.vh holds:
//    - BTB_DEPTH / BTB_IDX_W
//    - `JMP_EN / `JMP_DIS
//    - FSM encodings SCH_IDLE=1'b0, SCH_FLUSH=1'b1
//    - `MEM_ADDR_ZERO
//  - Sub-module btb_flush_walker contains the walk counter, the last-index detect and the
//    done pulse; the top holds the arbiter and the output register.
// TESTING
//  1. Reset, then idle: all outputs 0, ex_ready_o=id_ready_o=1.
//  2. EX valid pc=0x0000_0104 tgt=0x200 taken=1 -> next cycle:
//     wr_en=1, idx=1, tag=0x0000_0100>>6, target=0x200, valid=1.
//  3. EX and ID valid same cycle -> EX written at N+1, ID at N+2; id_ready_o=0 in cycle N.
//  4. flush_req_i pulse -> busy_o=1, 16 writes idx 0..15 valid=0, flush_done_o once,
//     ready low throughout.
//  5. flush_req_i again at walk idx 7 -> walk restarts at 0, and the total is 7+16 writes
//     before flush_done_o.
//  6. Guard defined: EX held valid 5 cycles, ID valid -> ID accepted in cycle 4 (STARVE_LIM);
//     undefined: ID accepted only after EX drops.

Source files
------------

// File: rtl/btb_upd_sched_pkg.sv
// Shared definitions for the BTB update scheduler: default geometry, write-valid
// encodings, scheduler state encoding and the write-source selector.
package btb_upd_sched_pkg;

    localparam int BTB_DEPTH = 16;
    localparam int BTB_IDX_W = 4;

    // Valid bit written into an entry: install vs. invalidate
    localparam logic JMP_EN  = 1'b1;
    localparam logic JMP_DIS = 1'b0;

    localparam logic [63:0] MEM_ADDR_ZERO = '0;

    typedef enum logic {
        SCH_IDLE  = 1'b0,
        SCH_FLUSH = 1'b1
    } sch_state_e;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_EX    = 2'd1,
        SRC_ID    = 2'd2,
        SRC_FLUSH = 2'd3
    } wr_src_e;

endpackage

// File: rtl/btb_upd_sched_if.sv
// Pipeline-side requests and BTB write port of the update scheduler.
// The slave modport is the scheduler; the master modport is the pipeline/BTB side.
interface btb_upd_sched_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4
);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [ADDR_W-1:0] ex_pc_i;
    logic [ADDR_W-1:0] ex_target_i;
    logic              ex_taken_i;

    logic              id_valid_i;
    logic              id_ready_o;
    logic [ADDR_W-1:0] id_pc_i;
    logic [ADDR_W-1:0] id_target_i;

    logic              flush_req_i;

    logic              btb_wr_en_o;
    logic [IDX_W-1:0]  btb_wr_idx_o;
    logic [TAG_W-1:0]  btb_wr_tag_o;
    logic [ADDR_W-1:0] btb_wr_target_o;
    logic              btb_wr_valid_o;

    logic              busy_o;
    logic              flush_done_o;

    modport slave (
        input  ex_valid_i, ex_pc_i, ex_target_i, ex_taken_i,
        input  id_valid_i, id_pc_i, id_target_i,
        input  flush_req_i,
        output ex_ready_o, id_ready_o,
        output btb_wr_en_o, btb_wr_idx_o, btb_wr_tag_o, btb_wr_target_o, btb_wr_valid_o,
        output busy_o, flush_done_o
    );

    modport master (
        output ex_valid_i, ex_pc_i, ex_target_i, ex_taken_i,
        output id_valid_i, id_pc_i, id_target_i,
        output flush_req_i,
        input  ex_ready_o, id_ready_o,
        input  btb_wr_en_o, btb_wr_idx_o, btb_wr_tag_o, btb_wr_target_o, btb_wr_valid_o,
        input  busy_o, flush_done_o
    );

endinterface

// File: rtl/btb_flush_walker.sv
// Full-table invalidate walk: IDLE/FLUSH state, walk counter, last-index detect
// and the flush-done pulse. Exposes next-cycle write intent so the top can register it.
module btb_flush_walker
    import btb_upd_sched_pkg::*;
#(
    parameter int DEPTH = BTB_DEPTH,
    parameter int IDX_W = BTB_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req_i,
    output logic             busy_o,
    output logic             wr_next_o,
    output logic [IDX_W-1:0] idx_next_o,
    output logic             done_o
);

    sch_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        last    = (cnt_q == IDX_W'(DEPTH - 1));
        case (state_q)
            SCH_IDLE: begin
                if (flush_req_i) begin
                    state_d = SCH_FLUSH;
                    cnt_d   = '0;
                end
            end
            SCH_FLUSH: begin
                // A new request abandons the current walk without a done pulse
                if (flush_req_i) begin
                    cnt_d = '0;
                end else if (last) begin
                    state_d = SCH_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCH_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = (state_q == SCH_FLUSH);
    assign wr_next_o  = (state_d == SCH_FLUSH);
    assign idx_next_o = cnt_d;
    assign done_o     = done_q;

endmodule

// File: rtl/btb_upd_sched.sv
// BTB write-port scheduler: arbitrates EX/ID updates against a full-table flush walk
// and registers the single write. Optional ID anti-starvation via BTB_STARVE_GUARD_EN.
module btb_upd_sched
    import btb_upd_sched_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = BTB_DEPTH,
    parameter int IDX_W      = BTB_IDX_W,
    parameter int STARVE_LIM = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    btb_upd_sched_if.slave bus
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    if (STARVE_LIM < 1 || (1 << IDX_W) != DEPTH) begin : g_bad_params
        $error("btb_upd_sched: DEPTH must equal 2**IDX_W and STARVE_LIM must be >= 1");
    end

    logic             walk_busy;
    logic             walk_wr_next;
    logic [IDX_W-1:0] walk_idx_next;
    logic             walk_done;

    logic             ready_base;
    logic             ex_ready, id_ready;
    logic             ex_acc, id_acc;
    wr_src_e          src;

    logic              wr_en_q, wr_en_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [TAG_W-1:0]  wr_tag_q, wr_tag_d;
    logic [ADDR_W-1:0] wr_target_q, wr_target_d;
    logic              wr_valid_q, wr_valid_d;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.ex_pc_i[1:0], bus.id_pc_i[1:0]};

    btb_flush_walker #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_walker (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_req_i (bus.flush_req_i),
        .busy_o      (walk_busy),
        .wr_next_o   (walk_wr_next),
        .idx_next_o  (walk_idx_next),
        .done_o      (walk_done)
    );

`ifdef BTB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIM + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              starving;

    assign starving = (wait_q >= WAIT_W'(STARVE_LIM));

    // Counts cycles ID is refused while idle; saturates at the limit
    always_comb begin
        wait_d = wait_q;
        if (bus.flush_req_i || walk_busy || id_acc) begin
            wait_d = '0;
        end else if (bus.id_valid_i && !id_ready && (wait_q < WAIT_W'(STARVE_LIM))) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    always_comb begin
        ready_base = !walk_busy && !bus.flush_req_i;
`ifdef BTB_STARVE_GUARD_EN
        ex_ready = ready_base && !starving;
        id_ready = starving ? ready_base : (ex_ready && !bus.ex_valid_i);
`else
        ex_ready = ready_base;
        id_ready = ex_ready && !bus.ex_valid_i;
`endif
        ex_acc = bus.ex_valid_i && ex_ready;
        id_acc = bus.id_valid_i && id_ready;
    end

    // Flush never coincides with an accept: both readies are low while walking or requested
    always_comb begin
        src = SRC_NONE;
        if (walk_wr_next) begin
            src = SRC_FLUSH;
        end else if (ex_acc) begin
            src = SRC_EX;
        end else if (id_acc) begin
            src = SRC_ID;
        end

        wr_en_d     = 1'b0;
        wr_idx_d    = '0;
        wr_tag_d    = '0;
        wr_target_d = '0;
        wr_valid_d  = 1'b0;
        case (src)
            SRC_FLUSH: begin
                wr_en_d     = 1'b1;
                wr_idx_d    = walk_idx_next;
                wr_target_d = MEM_ADDR_ZERO[ADDR_W-1:0];
                wr_valid_d  = JMP_DIS;
            end
            SRC_EX: begin
                wr_en_d     = 1'b1;
                wr_idx_d    = bus.ex_pc_i[IDX_W+1:2];
                wr_tag_d    = bus.ex_pc_i[ADDR_W-1:IDX_W+2];
                wr_target_d = bus.ex_target_i;
                wr_valid_d  = bus.ex_taken_i;
            end
            SRC_ID: begin
                wr_en_d     = 1'b1;
                wr_idx_d    = bus.id_pc_i[IDX_W+1:2];
                wr_tag_d    = bus.id_pc_i[ADDR_W-1:IDX_W+2];
                wr_target_d = bus.id_target_i;
                wr_valid_d  = JMP_EN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q     <= 1'b0;
            wr_idx_q    <= '0;
            wr_tag_q    <= '0;
            wr_target_q <= '0;
            wr_valid_q  <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_idx_q    <= wr_idx_d;
            wr_tag_q    <= wr_tag_d;
            wr_target_q <= wr_target_d;
            wr_valid_q  <= wr_valid_d;
        end
    end

    assign bus.ex_ready_o      = ex_ready;
    assign bus.id_ready_o      = id_ready;
    assign bus.btb_wr_en_o     = wr_en_q;
    assign bus.btb_wr_idx_o    = wr_idx_q;
    assign bus.btb_wr_tag_o    = wr_tag_q;
    assign bus.btb_wr_target_o = wr_target_q;
    assign bus.btb_wr_valid_o  = wr_valid_q;
    assign bus.busy_o          = walk_busy;
    assign bus.flush_done_o    = walk_done;

endmodule

// File: tb/tb_btb_upd_sched.sv
// Self-checking bench for btb_upd_sched: directed scenarios plus a randomized run
// against a cycle-level reference model built from the scheduling rules.
module tb_btb_upd_sched;

    localparam int ADDR_W     = 32;
    localparam int DEPTH      = 16;
    localparam int IDX_W      = 4;
    localparam int TAG_W      = ADDR_W - IDX_W - 2;
    localparam int STARVE_LIM = 4;
`ifdef BTB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btb_upd_sched_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

    btb_upd_sched #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // {en, idx, tag, target, valid}
    function automatic logic [63:0] wr_word(input logic [31:0] pc, input logic [31:0] tgt,
                                            input logic vld);
        return {1'b1, pc[IDX_W+1:2], pc[ADDR_W-1:IDX_W+2], tgt, vld};
    endfunction

    function automatic logic [63:0] flush_word(input int idx);
        return {1'b1, IDX_W'(idx), {TAG_W{1'b0}}, 32'd0, 1'b0};
    endfunction

    function automatic logic [63:0] obs_wr();
        return {bus.btb_wr_en_o, bus.btb_wr_idx_o, bus.btb_wr_tag_o,
                bus.btb_wr_target_o, bus.btb_wr_valid_o};
    endfunction

    task automatic drive_idle();
        bus.ex_valid_i  = 1'b0;
        bus.ex_pc_i     = '0;
        bus.ex_target_i = '0;
        bus.ex_taken_i  = 1'b0;
        bus.id_valid_i  = 1'b0;
        bus.id_pc_i     = '0;
        bus.id_target_i = '0;
        bus.flush_req_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({obs_wr(), bus.busy_o, bus.flush_done_o} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_hold: got wr=%h busy=%b done=%b required all 0",
                     obs_wr(), bus.busy_o, bus.flush_done_o);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({obs_wr(), bus.busy_o, bus.flush_done_o} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_idle_outputs: got wr=%h busy=%b done=%b required all 0",
                     obs_wr(), bus.busy_o, bus.flush_done_o);
        end
        n_cmp++;
        if ({bus.ex_ready_o, bus.id_ready_o} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_idle_ready: got %b required 11",
                     {bus.ex_ready_o, bus.id_ready_o});
        end
    endtask

    task automatic test_ex_single();
        tick();
        bus.ex_valid_i  = 1'b1;
        bus.ex_pc_i     = 32'h0000_0104;
        bus.ex_target_i = 32'h0000_0200;
        bus.ex_taken_i  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.ex_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL ex_single_ready: got %b required 1", bus.ex_ready_o);
        end
        tick();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (obs_wr() !== {1'b1, 4'd1, 26'd4, 32'h0000_0200, 1'b1}) begin
            n_err++;
            $display("FAIL ex_single_write: got %h required %h", obs_wr(),
                     {1'b1, 4'd1, 26'd4, 32'h0000_0200, 1'b1});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus.btb_wr_en_o !== 1'b0) begin
            n_err++;
            $display("FAIL ex_single_one_shot: got wr_en=%b required 0", bus.btb_wr_en_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] prev;
        prev = '0;
        for (int i = 0; i <= 6; i++) begin
            tick();
            if (i < 6) begin
                bus.ex_valid_i  = 1'b1;
                bus.ex_pc_i     = $urandom;
                bus.ex_target_i = $urandom;
                bus.ex_taken_i  = i[0];
            end else begin
                drive_idle();
            end
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (obs_wr() !== prev) begin
                    n_err++;
                    $display("FAIL b2b_write[%0d]: got %h required %h", i - 1, obs_wr(), prev);
                end
            end
            if (i < 6) begin
                n_cmp++;
                if (bus.ex_ready_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_ready[%0d]: got %b required 1", i, bus.ex_ready_o);
                end
                prev = wr_word(bus.ex_pc_i, bus.ex_target_i, bus.ex_taken_i);
            end
        end
    endtask

    task automatic test_ex_id_conflict();
        logic [63:0] ex_exp, id_exp;
        tick();
        bus.ex_valid_i  = 1'b1;
        bus.ex_pc_i     = $urandom;
        bus.ex_target_i = $urandom;
        bus.ex_taken_i  = 1'b0;
        bus.id_valid_i  = 1'b1;
        bus.id_pc_i     = $urandom;
        bus.id_target_i = $urandom;
        ex_exp = wr_word(bus.ex_pc_i, bus.ex_target_i, 1'b0);
        id_exp = wr_word(bus.id_pc_i, bus.id_target_i, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({bus.ex_ready_o, bus.id_ready_o} !== 2'b10) begin
            n_err++;
            $display("FAIL conflict_ready_n: got %b required 10",
                     {bus.ex_ready_o, bus.id_ready_o});
        end
        tick();
        bus.ex_valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs_wr() !== ex_exp) begin
            n_err++;
            $display("FAIL conflict_ex_write: got %h required %h", obs_wr(), ex_exp);
        end
        n_cmp++;
        if (bus.id_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_id_ready_n1: got %b required 1", bus.id_ready_o);
        end
        tick();
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (obs_wr() !== id_exp) begin
            n_err++;
            $display("FAIL conflict_id_write: got %h required %h", obs_wr(), id_exp);
        end
    endtask

    task automatic test_flush();
        logic [63:0] ex_exp, exp;
        tick();
        bus.flush_req_i = 1'b1;
        bus.ex_valid_i  = 1'b1;
        bus.ex_pc_i     = $urandom;
        bus.ex_target_i = $urandom;
        bus.ex_taken_i  = 1'b1;
        ex_exp = wr_word(bus.ex_pc_i, bus.ex_target_i, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({bus.ex_ready_o, bus.id_ready_o} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_req_ready: got %b required 00", {bus.ex_ready_o, bus.id_ready_o});
        end
        tick();
        bus.flush_req_i = 1'b0;
        for (int cyc = 0; cyc <= 17; cyc++) begin
            @(negedge clk);
            exp = (cyc < DEPTH) ? flush_word(cyc) : (cyc == DEPTH + 1) ? ex_exp : 64'd0;
            n_cmp++;
            if (obs_wr() !== exp) begin
                n_err++;
                $display("FAIL flush_write[%0d]: got %h required %h", cyc, obs_wr(), exp);
            end
            if (cyc <= DEPTH) begin
                n_cmp++;
                if ({bus.busy_o, bus.flush_done_o, bus.ex_ready_o} !==
                    ((cyc < DEPTH) ? 3'b100 : 3'b011)) begin
                    n_err++;
                    $display("FAIL flush_status[%0d]: got busy/done/ex_ready=%b required %b", cyc,
                             {bus.busy_o, bus.flush_done_o, bus.ex_ready_o},
                             (cyc < DEPTH) ? 3'b100 : 3'b011);
                end
            end
            tick();
            if (cyc == DEPTH) bus.ex_valid_i = 1'b0;
        end
        drive_idle();
    endtask

    task automatic test_flush_restart();
        int writes, dones;
        logic [63:0] exp;
        writes = 0;
        dones  = 0;
        tick();
        bus.flush_req_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        for (int cyc = 0; cyc <= 23; cyc++) begin
            @(negedge clk);
            exp = (cyc < 7) ? flush_word(cyc) : (cyc < 23) ? flush_word(cyc - 7) : 64'd0;
            n_cmp++;
            if (obs_wr() !== exp) begin
                n_err++;
                $display("FAIL restart_write[%0d]: got %h required %h", cyc, obs_wr(), exp);
            end
            if (bus.btb_wr_en_o === 1'b1) writes++;
            if (bus.flush_done_o === 1'b1) dones++;
            if (cyc == 6) bus.flush_req_i = 1'b1;
            tick();
            bus.flush_req_i = 1'b0;
        end
        n_cmp++;
        if (writes !== 23 || dones !== 1) begin
            n_err++;
            $display("FAIL restart_totals: got writes=%0d dones=%0d required writes=23 dones=1",
                     writes, dones);
        end
    endtask

    task automatic test_starve();
        int ex_accepts, id_cyc, exp_cyc;
        bit ex_now, id_now, chk_id;
        logic [63:0] id_exp;
        ex_accepts = 0;
        id_cyc     = -1;
        chk_id     = 1'b0;
        exp_cyc    = GUARD ? STARVE_LIM : 5;
        tick();
        bus.ex_valid_i  = 1'b1;
        bus.ex_pc_i     = $urandom;
        bus.ex_target_i = $urandom;
        bus.ex_taken_i  = 1'b1;
        bus.id_valid_i  = 1'b1;
        bus.id_pc_i     = $urandom;
        bus.id_target_i = $urandom;
        id_exp = wr_word(bus.id_pc_i, bus.id_target_i, 1'b1);
        for (int cyc = 0; cyc < 20 && (ex_accepts < 5 || id_cyc < 0 || chk_id); cyc++) begin
            @(negedge clk);
            if (chk_id) begin
                chk_id = 1'b0;
                n_cmp++;
                if (obs_wr() !== id_exp) begin
                    n_err++;
                    $display("FAIL starve_id_write: got %h required %h", obs_wr(), id_exp);
                end
            end
            ex_now = bus.ex_valid_i && bus.ex_ready_o;
            id_now = bus.id_valid_i && bus.id_ready_o;
            if (id_now) begin
                id_cyc = cyc;
                chk_id = 1'b1;
            end
            tick();
            if (ex_now) begin
                ex_accepts++;
                if (ex_accepts == 5) begin
                    bus.ex_valid_i = 1'b0;
                end else begin
                    bus.ex_pc_i     = $urandom;
                    bus.ex_target_i = $urandom;
                end
            end
            if (id_now) bus.id_valid_i = 1'b0;
        end
        n_cmp++;
        if (id_cyc !== exp_cyc || ex_accepts !== 5) begin
            n_err++;
            $display("FAIL starve_id_cycle: got id_cycle=%0d ex_accepts=%0d required %0d and 5",
                     id_cyc, ex_accepts, exp_cyc);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_flush();
        int dones;
        dones = 0;
        tick();
        bus.flush_req_i = 1'b1;
        tick();
        bus.flush_req_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy_o, bus.btb_wr_en_o, bus.flush_done_o} !== 3'b000) begin
            n_err++;
            $display("FAIL midflush_async: got busy/wr_en/done=%b required 000",
                     {bus.busy_o, bus.btb_wr_en_o, bus.flush_done_o});
        end
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.flush_done_o === 1'b1) dones++;
            n_cmp++;
            if ({bus.busy_o, bus.btb_wr_en_o} !== 2'b00) begin
                n_err++;
                $display("FAIL midflush_idle[%0d]: got busy/wr_en=%b required 00", cyc,
                         {bus.busy_o, bus.btb_wr_en_o});
            end
            tick();
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL midflush_no_done: got %0d done pulses required 0", dones);
        end
    endtask

    task automatic test_random();
        bit          m_flush, m_done, idle, starving, exr, idr, exa, ida, fr, exv, idv;
        int          m_idx, m_wait;
        logic [63:0] m_wr, exp;
        m_flush = 1'b0;
        m_done  = 1'b0;
        m_idx   = 0;
        m_wait  = 0;
        m_wr    = '0;
        tick();
        rst_n = 1'b0;
        drive_idle();
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            fr  = bus.flush_req_i;
            exv = bus.ex_valid_i;
            idv = bus.id_valid_i;
            idle     = !m_flush;
            starving = GUARD && (m_wait >= STARVE_LIM);
            exr = idle && !fr && !starving;
            idr = starving ? (idle && !fr) : (exr && !exv);
            exp = m_flush ? flush_word(m_idx) : m_wr;
            n_cmp++;
            if (obs_wr() !== exp) begin
                n_err++;
                $display("FAIL rand_write[%0d]: got %h required %h", cyc, obs_wr(), exp);
            end
            n_cmp++;
            if ({bus.ex_ready_o, bus.id_ready_o} !== {exr, idr}) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: got %b required %b", cyc,
                         {bus.ex_ready_o, bus.id_ready_o}, {exr, idr});
            end
            n_cmp++;
            if ({bus.busy_o, bus.flush_done_o} !== {m_flush, m_done}) begin
                n_err++;
                $display("FAIL rand_status[%0d]: got busy/done=%b required %b", cyc,
                         {bus.busy_o, bus.flush_done_o}, {m_flush, m_done});
            end
            exa = exv && exr;
            ida = idv && idr;
            m_wr = exa ? wr_word(bus.ex_pc_i, bus.ex_target_i, bus.ex_taken_i) :
                   ida ? wr_word(bus.id_pc_i, bus.id_target_i, 1'b1) : 64'd0;
            if (fr || !idle || ida) m_wait = 0;
            else if (idv && !idr && m_wait < STARVE_LIM) m_wait++;
            m_done = 1'b0;
            if (fr) begin
                m_flush = 1'b1;
                m_idx   = 0;
            end else if (m_flush) begin
                if (m_idx == DEPTH - 1) begin
                    m_flush = 1'b0;
                    m_done  = 1'b1;
                end else begin
                    m_idx++;
                end
            end
            tick();
            bus.flush_req_i = ($urandom_range(0, 49) == 0);
            if (exa || !exv) begin
                bus.ex_valid_i  = ($urandom_range(0, 2) != 0);
                bus.ex_pc_i     = $urandom;
                bus.ex_target_i = $urandom;
                bus.ex_taken_i  = $urandom_range(0, 1);
            end
            if (ida || !idv) begin
                bus.id_valid_i  = $urandom_range(0, 1);
                bus.id_pc_i     = $urandom;
                bus.id_target_i = $urandom;
            end
        end
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        test_reset();
        test_ex_single();
        test_back_to_back();
        test_ex_id_conflict();
        test_flush();
        test_flush_restart();
        test_starve();
        test_reset_mid_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
